// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port, one
// asynchronous read port, data is never reset.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  fetch_entry_t wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output fetch_entry_t rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequentially from imem into a DEPTH-entry
// FIFO, flushes on redirect. Define FETCH_QUEUE_STATS_EN to add full_cycles.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 18,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [ADDR_W-1:0]    imem_a,
  input  logic [INSTR_W-1:0]   imem_rd,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic                 deq_valid,
  input  logic                 deq_ready,
  output logic [INSTR_W-1:0]   deq_instr,
  output logic [31:0]          deq_pc,
`ifdef FETCH_QUEUE_STATS_EN
  output logic [31:0]          full_cycles,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0]      fpc_q, fpc_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic         full;
  logic         do_deq;
  logic         do_enq;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign deq_valid = (count_q != '0);
  // A redirect cancels both sides of the handshake for its cycle.
  assign do_deq    = deq_valid && deq_ready && !redirect;
  assign do_enq    = !redirect && (!full || do_deq);

  assign wr_entry  = '{pc: fpc_q, instr: imem_rd};

  always_comb begin
    fpc_d   = fpc_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (redirect) begin
      fpc_d   = redirect_pc & 32'hFFFF_FFFC;
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) begin
        fpc_d  = fpc_q + 32'd4;
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (do_deq) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      unique case ({do_enq, do_deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q   <= RESET_PC_ALIGNED;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      fpc_q   <= fpc_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (do_enq),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_o (head)
  );

  // Storage is unreset, so outputs are masked to zero whenever the queue is empty.
  assign imem_a    = fpc_q[ADDR_W+1:2];
  assign deq_pc    = deq_valid ? head.pc    : '0;
  assign deq_instr = deq_valid ? head.instr : '0;
  assign count     = count_q;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] full_cycles_q, full_cycles_d;

  always_comb begin
    full_cycles_d = full_cycles_q;
    if (full && !do_deq && !redirect && (full_cycles_q != 32'hFFFF_FFFF)) begin
      full_cycles_d = full_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_cycles_q <= '0;
    end else begin
      full_cycles_q <= full_cycles_d;
    end
  end

  assign full_cycles = full_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-level reference model pushes
// expected entries, a monitor pops and compares them as the DUT dequeues.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          ADDR_W   = 18;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [ADDR_W-1:0]     imem_a;
  logic [31:0]           imem_rd;
  logic                  redirect = 1'b0;
  logic [31:0]           redirectPcIn = 32'h0;
  logic                  deq_valid;
  logic                  deq_ready = 1'b0;
  logic [31:0]           deq_instr;
  logic [31:0]           deq_pc;
  logic [$clog2(DEPTH):0] count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0]           full_cycles;
`endif

  int checks = 0;
  int errors = 0;

  fetch_entry_t expQ[$];
  int           mCount = 0;
  logic [31:0]  mfpc = RESET_PC;
  logic [31:0]  fullCycles = 32'h0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]} ^ {14'h0, a};
  endfunction

  assign imem_rd = memWord(imem_a);

  fetch_queue #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_a      (imem_a),
    .imem_rd     (imem_rd),
    .redirect    (redirect),
    .redirect_pc (redirectPcIn),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_instr   (deq_instr),
    .deq_pc      (deq_pc),
`ifdef FETCH_QUEUE_STATS_EN
    .full_cycles (full_cycles),
`endif
    .count       (count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the queue as a list of {pc, instr}, advanced once per clock.
  always @(posedge clk or negedge reset) begin
    bit deq;
    bit enq;
    if (!reset) begin
      expQ.delete();
      mCount     = 0;
      mfpc       = RESET_PC;
      fullCycles = 32'h0;
    end else if (redirect) begin
      expQ.delete();
      mCount = 0;
      mfpc   = {redirectPcIn[31:2], 2'b00};
    end else begin
      deq = (mCount != 0) && deq_ready;
      enq = (mCount < DEPTH) || deq;
      if (mCount == DEPTH && !deq && fullCycles != 32'hFFFF_FFFF) fullCycles = fullCycles + 1;
      if (enq) begin
        expQ.push_back('{pc: mfpc, instr: memWord(mfpc[ADDR_W+1:2])});
        mfpc = mfpc + 32'd4;
      end
      mCount = mCount + int'(enq) - int'(deq);
    end
  end

  // Monitor: mid-cycle compare of the presented head, pops on accepted handshakes.
  always @(negedge clk or negedge reset) begin
    fetch_entry_t head;
    if (!reset) begin
      #1;
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_valid", 32'(deq_valid), 32'd0);
      checkOutput("rst_pc", deq_pc, 32'd0);
      checkOutput("rst_instr", deq_instr, 32'd0);
      checkOutput("rst_imem_a", 32'(imem_a), 32'(RESET_PC[ADDR_W+1:2]));
    end else begin
      checkOutput("count", 32'(count), 32'(mCount));
      checkOutput("valid", 32'(deq_valid), 32'(mCount != 0));
      checkOutput("imem_a", 32'(imem_a), 32'(mfpc[ADDR_W+1:2]));
`ifdef FETCH_QUEUE_STATS_EN
      checkOutput("full_cycles", full_cycles, fullCycles);
`endif
      if (expQ.size() != 0) begin
        head = expQ[0];
        checkOutput("deq_pc", deq_pc, head.pc);
        checkOutput("deq_instr", deq_instr, head.instr);
        if (deq_ready && !redirect) void'(expQ.pop_front());
      end else begin
        checkOutput("idle_pc", deq_pc, 32'd0);
        checkOutput("idle_instr", deq_instr, 32'd0);
      end
    end
  end

  // Holds the given inputs for a number of cycles, changing them just after posedge.
  task automatic applyStimulus(input int cycles, input bit ready, input bit redir, input logic [31:0] rpc);
    for (int i = 0; i < cycles; i++) begin
      deq_ready    = ready;
      redirect     = redir;
      redirectPcIn = rpc;
      @(posedge clk);
      #1;
    end
    redirect = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    applyStimulus(6, 1'b1, 1'b0, 32'h0);
    applyStimulus(1, 1'b0, 1'b1, 32'h0);
    applyStimulus(10, 1'b0, 1'b0, 32'h0);
    applyStimulus(1, 1'b0, 1'b1, 32'h100);
    applyStimulus(4, 1'b1, 1'b0, 32'h0);
    applyStimulus(1, 1'b0, 1'b1, 32'h103);
    applyStimulus(3, 1'b0, 1'b0, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    applyStimulus(6, 1'b1, 1'b0, 32'h0);

    applyStimulus(1, 1'b0, 1'b1, 32'h200);
    applyStimulus(3, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(5, 1'b1, 1'b0, 32'h0);

    for (int seg = 0; seg < 40; seg++) begin
      int readyBias;
      readyBias = $urandom_range(0, 4);
      for (int i = 0; i < 50; i++) begin
        applyStimulus(1, $urandom_range(0, 4) < readyBias, $urandom_range(0, 19) == 0, $urandom);
      end
    end
    applyStimulus(3, 1'b1, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
